// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, keeps at most one instruction-memory
// request outstanding and hands fetched words to decode over a valid/ready handshake.
// Redirects from execute squash in-flight or held work and always win over
// handshake and data events in the same cycle.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Start,
   input  logic        Halt,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemGnt,
   input  logic        IMemRValid,
   input  logic [31:0] IMemRData,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [31:0] InstrPC,
   input  logic        DecodeReady,
   output logic [31:0] FetchPC,
   output logic [31:0] RetireCount
);

   localparam logic [31:0] PcStep = 32'(PC_STEP);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic [31:0] retire_q, retire_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] redirect_pc;

   // Targets are word aligned; the low two bits from execute are dropped.
   assign redirect_pc = {RedirectPC[31:2], 2'b00};

   // Next-state and datapath update; redirect is tested before any other event.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      retire_d      = retire_q;
      instr_valid_d = instr_valid_q;
      unique case (state_q)
         StIdle: begin
            if (Redirect) fetch_pc_d = redirect_pc;
            if (Start && !Halt) state_d = StReq;
         end
         StReq: begin
            if (Redirect) fetch_pc_d = redirect_pc;
            // A granted request under redirect is stale; its response must be drained.
            if (IMemGnt) state_d = Redirect ? StDrop : StWait;
         end
         StWait: begin
            if (Redirect) begin
               fetch_pc_d = redirect_pc;
               state_d    = IMemRValid ? StReq : StDrop;
            end else if (IMemRValid) begin
               instr_d       = IMemRData;
               instr_pc_d    = fetch_pc_q;
               instr_valid_d = 1'b1;
               fetch_pc_d    = fetch_pc_q + PcStep;
               state_d       = StHold;
            end
         end
         StDrop: begin
            if (Redirect) fetch_pc_d = redirect_pc;
            // The stale response retires the outstanding request even if a redirect
            // lands in the same cycle, otherwise nothing would ever release DROP.
            if (IMemRValid) state_d = StReq;
         end
         StHold: begin
            if (Redirect) begin
               instr_valid_d = 1'b0;
               fetch_pc_d    = redirect_pc;
               state_d       = Halt ? StIdle : StReq;
            end else if (DecodeReady) begin
               instr_valid_d = 1'b0;
               retire_d      = retire_q + 32'd1;
               state_d       = Halt ? StIdle : StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with asynchronous active-high reset.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q       <= StIdle;
         fetch_pc_q    <= RESET_PC;
         instr_q       <= 32'd0;
         instr_pc_q    <= 32'd0;
         retire_q      <= 32'd0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         retire_q      <= retire_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign IMemReq     = (state_q == StReq);
   assign IMemAddr    = fetch_pc_q;
   assign FetchPC     = fetch_pc_q;
   assign InstrValid  = instr_valid_q;
   assign Instr       = instr_q;
   assign InstrPC     = instr_pc_q;
   assign RetireCount = retire_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (RESET_PC 0 and 0xFFFF_FFFC) share stimulus
// from a latency-randomised memory model; a transaction-level reference model predicts
// every output each cycle, and directed sequences pin key values with literals.
module tb_fetch_sequencer;

   logic        CLK, Reset, Start, Halt, Redirect, IMemGnt, IMemRValid, DecodeReady;
   logic [31:0] RedirectPC, IMemRData;
   logic        imem_req [2];
   logic        instr_valid [2];
   logic [31:0] imem_addr [2];
   logic [31:0] instr [2];
   logic [31:0] instr_pc [2];
   logic [31:0] fetch_pc [2];
   logic [31:0] retire [2];

   int checks = 0;
   int failures = 0;

   fetch_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut0 (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .IMemReq(imem_req[0]), .IMemAddr(imem_addr[0]),
      .IMemGnt(IMemGnt), .IMemRValid(IMemRValid), .IMemRData(IMemRData),
      .InstrValid(instr_valid[0]), .Instr(instr[0]), .InstrPC(instr_pc[0]),
      .DecodeReady(DecodeReady), .FetchPC(fetch_pc[0]), .RetireCount(retire[0])
   );

   fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_dut1 (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .IMemReq(imem_req[1]), .IMemAddr(imem_addr[1]),
      .IMemGnt(IMemGnt), .IMemRValid(IMemRValid), .IMemRData(IMemRData),
      .InstrValid(instr_valid[1]), .Instr(instr[1]), .InstrPC(instr_pc[1]),
      .DecodeReady(DecodeReady), .FetchPC(fetch_pc[1]), .RetireCount(retire[1])
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Transaction view: running or not, a request outstanding (possibly stale),
   // an instruction presented to decode.
   typedef struct {
      logic        run;
      logic        out;
      logic        stale;
      logic        hold;
      logic [31:0] fpc;
      logic [31:0] ipc;
      logic [31:0] word;
      logic [31:0] ret;
   } mdl_t;

   mdl_t m [2];

   function automatic logic [31:0] rst_pc(input int d);
      return (d == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
   endfunction

   function automatic mdl_t mreset(input int d);
      mdl_t r;
      r.run = 1'b0; r.out = 1'b0; r.stale = 1'b0; r.hold = 1'b0;
      r.fpc = rst_pc(d); r.ipc = 32'd0; r.word = 32'd0; r.ret = 32'd0;
      return r;
   endfunction

   function automatic mdl_t mstep(input mdl_t cur, input logic start, input logic halt,
                                  input logic red, input logic [31:0] rpc_raw,
                                  input logic gnt, input logic rv,
                                  input logic [31:0] rdata, input logic ready);
      mdl_t r;
      logic [31:0] rpc;
      r = cur;
      rpc = rpc_raw & 32'hFFFF_FFFC;
      if (!cur.run) begin
         if (red) r.fpc = rpc;
         if (start && !halt) r.run = 1'b1;
      end else if (cur.hold) begin
         if (red || ready) begin
            r.hold = 1'b0;
            r.run  = !halt;
            if (red) r.fpc = rpc;
            else r.ret = cur.ret + 1;
         end
      end else if (!cur.out) begin
         if (red) r.fpc = rpc;
         if (gnt) begin
            r.out = 1'b1;
            r.stale = red;
         end
      end else begin
         if (red) r.fpc = rpc;
         if (rv) begin
            r.out = 1'b0;
            if (!cur.stale && !red) begin
               r.hold = 1'b1;
               r.word = rdata;
               r.ipc  = cur.fpc;
               r.fpc  = cur.fpc + 4;
            end
         end else if (red) begin
            r.stale = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(posedge CLK) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("imem_req%0d", d), {31'd0, imem_req[d]},
             {31'd0, m[d].run && !m[d].out && !m[d].hold});
         chk($sformatf("imem_addr%0d", d), imem_addr[d], m[d].fpc);
         chk($sformatf("fetch_pc%0d", d), fetch_pc[d], m[d].fpc);
         chk($sformatf("instr_valid%0d", d), {31'd0, instr_valid[d]}, {31'd0, m[d].hold});
         chk($sformatf("retire%0d", d), retire[d], m[d].ret);
         if (m[d].hold) begin
            chk($sformatf("instr%0d", d), instr[d], m[d].word);
            chk($sformatf("instr_pc%0d", d), instr_pc[d], m[d].ipc);
         end
      end
   end

   // Stimulus knobs and memory model state.
   logic        rst_v, start_v, halt_v, red_v, ready_v;
   logic [31:0] redpc_v, resp_data, last_rdata;
   int          gnt_pct, lat_min, lat_max, resp_cnt;

   task automatic step();
      logic gnt, rv;
      @(negedge CLK);
      rv  = (resp_cnt == 1);
      gnt = !rst_v && imem_req[0] && (resp_cnt == 0) && ($urandom_range(99) < gnt_pct);
      Reset       = rst_v;
      Start       = start_v;
      Halt        = halt_v;
      Redirect    = red_v;
      RedirectPC  = redpc_v;
      DecodeReady = ready_v;
      IMemGnt     = gnt;
      IMemRValid  = rv;
      IMemRData   = rv ? resp_data : $urandom();
      if (rv) last_rdata = resp_data;
      if (resp_cnt > 0) resp_cnt--;
      if (gnt) begin
         resp_cnt  = $urandom_range(lat_max, lat_min);
         resp_data = $urandom();
      end
      for (int d = 0; d < 2; d++) begin
         if (rst_v) m[d] = mreset(d);
         else m[d] = mstep(m[d], start_v, halt_v, red_v, redpc_v, gnt, rv, IMemRData, ready_v);
      end
      @(posedge CLK);
      #2;
   endtask

   initial begin
      logic [31:0] saved;
      rst_v = 1'b1; start_v = 1'b0; halt_v = 1'b0; red_v = 1'b0; ready_v = 1'b1;
      redpc_v = 32'd0; gnt_pct = 100; lat_min = 1; lat_max = 1; resp_cnt = 0;
      resp_data = 32'd0; last_rdata = 32'd0;
      Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Redirect = 1'b0; RedirectPC = 32'd0;
      DecodeReady = 1'b0; IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = 32'd0;
      m[0] = mreset(0);
      m[1] = mreset(1);
      step();
      step();
      chk("rst_valid", {31'd0, instr_valid[0]}, 32'd0);
      chk("rst_req", {31'd0, imem_req[0]}, 32'd0);
      chk("rst_fpc0", fetch_pc[0], 32'h0000_0000);
      chk("rst_fpc1", fetch_pc[1], 32'hFFFF_FFFC);
      chk("rst_retire", retire[0], 32'd0);
      chk("rst_instr", instr[0], 32'd0);
      chk("rst_ipc", instr_pc[0], 32'd0);

      // Back-to-back fetch with single-cycle memory and decode always ready.
      rst_v = 1'b0; start_v = 1'b1;
      step();
      chk("start_req", {31'd0, imem_req[0]}, 32'd1);
      chk("start_addr", imem_addr[0], 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("wait_req_low", {31'd0, imem_req[0]}, 32'd0);
         step();
         chk("hold_valid", {31'd0, instr_valid[0]}, 32'd1);
         chk("hold_ipc", instr_pc[0], 32'(4 * k));
         chk("hold_instr", instr[0], last_rdata);
         chk("hold_req_low", {31'd0, imem_req[0]}, 32'd0);
         chk("hold_fpc", fetch_pc[0], 32'(4 * k + 4));
         if (k == 0) begin
            chk("wrap_ipc", instr_pc[1], 32'hFFFF_FFFC);
            chk("wrap_fpc", fetch_pc[1], 32'h0000_0000);
         end
         step();
         chk("hs_retire", retire[0], 32'(k + 1));
         chk("hs_valid", {31'd0, instr_valid[0]}, 32'd0);
      end
      chk("retire3", retire[0], 32'd3);
      start_v = 1'b0;

      // Redirect in WAIT before the response: it must be dropped.
      lat_min = 2; lat_max = 2;
      step();
      red_v = 1'b1; redpc_v = 32'h0000_0103;
      step();
      red_v = 1'b0;
      chk("drop_req_low", {31'd0, imem_req[0]}, 32'd0);
      chk("drop_fpc0", fetch_pc[0], 32'h100);
      chk("drop_fpc1", fetch_pc[1], 32'h100);
      lat_min = 1; lat_max = 1;
      step();
      chk("drop_no_valid", {31'd0, instr_valid[0]}, 32'd0);
      chk("redir_req", {31'd0, imem_req[0]}, 32'd1);
      chk("redir_addr", imem_addr[0], 32'h100);
      step();
      step();
      chk("redir_valid", {31'd0, instr_valid[0]}, 32'd1);
      chk("redir_ipc", instr_pc[0], 32'h100);

      // Decode stalls five cycles: held instruction stays put, no new request.
      ready_v = 1'b0;
      saved = last_rdata;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_valid", {31'd0, instr_valid[0]}, 32'd1);
         chk("stall_ipc", instr_pc[0], 32'h100);
         chk("stall_instr", instr[0], saved);
         chk("stall_req", {31'd0, imem_req[0]}, 32'd0);
         chk("stall_fpc", fetch_pc[0], 32'h104);
      end

      // Redirect together with DecodeReady: squashed, not retired.
      ready_v = 1'b1; red_v = 1'b1; redpc_v = 32'h0000_0200;
      step();
      red_v = 1'b0;
      chk("sq_valid", {31'd0, instr_valid[0]}, 32'd0);
      chk("sq_retire", retire[0], 32'd3);
      chk("sq_req", {31'd0, imem_req[0]}, 32'd1);
      chk("sq_addr", imem_addr[0], 32'h200);

      // Reset during WAIT; the abandoned response arrives two cycles after release.
      lat_min = 4; lat_max = 4;
      step();
      rst_v = 1'b1;
      step();
      rst_v = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("late_valid", {31'd0, instr_valid[0]}, 32'd0);
         chk("late_req", {31'd0, imem_req[0]}, 32'd0);
         chk("late_fpc0", fetch_pc[0], 32'h0);
         chk("late_fpc1", fetch_pc[1], 32'hFFFF_FFFC);
         chk("late_retire", retire[0], 32'd0);
      end

      // Randomised traffic against the model.
      gnt_pct = 60; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         rst_v   = ($urandom_range(999) < 3);
         start_v = ($urandom_range(99) < 40);
         halt_v  = ($urandom_range(99) < 6);
         red_v   = ($urandom_range(99) < 7);
         redpc_v = $urandom();
         ready_v = ($urandom_range(99) < 60);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the RV32I datapath: owns the fetch PC, issues one instruction-memory request at a time, and presents fetched instructions to decode with a valid/ready handshake.
- Accepts PC redirects from execute (jump, jalr, taken branch) and squashes any in-flight or held instruction.
- Sits between the instruction memory and the decode stage; it replaces free-running PC advance with stall-aware sequencing.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  leave IDLE and begin fetching.
- Halt  input  1  return to IDLE after the current instruction is consumed.
- Redirect  input  1  one-cycle strobe: load RedirectPC, squash in-flight work.
- RedirectPC  input  32  redirect target; bits [1:0] ignored (forced 0).
- IMemReq  output  1  request valid to instruction memory.
- IMemAddr  output  32  request address (equals FetchPC).
- IMemGnt  input  1  memory accepted the request this cycle.
- IMemRValid  input  1  read data valid (earliest one cycle after grant).
- IMemRData  input  32  read data.
- InstrValid  output  1  instruction available to decode.
- Instr  output  32  instruction word.
- InstrPC  output  32  PC of Instr.
- DecodeReady  input  1  decode accepts Instr when InstrValid is high.
- FetchPC  output  32  current fetch PC.
- RetireCount  output  32  count of instructions accepted by decode.

Behaviour:
- Reset (async): state=IDLE; FetchPC=RESET_PC; IMemReq=0; InstrValid=0; Instr=0; InstrPC=0; RetireCount=0. Asserting reset mid-transaction abandons it. Any response arriving after reset is ignored, because the FSM is not in WAIT/DROP.
- At most one outstanding memory request. All outputs are registered, except that IMemReq and IMemAddr are decoded from state and FetchPC.
- IDLE:
  - Start=1 and Halt=0 -> REQ.
  - Redirect in IDLE updates FetchPC only.
- REQ: IMemReq=1, IMemAddr=FetchPC.
  - Gnt=1, no Redirect -> WAIT.
  - Gnt=1 with Redirect -> FetchPC<=RedirectPC, go to DROP.
  - Gnt=0 with Redirect -> FetchPC<=RedirectPC, stay in REQ.
- WAIT:
  - RValid=1, no Redirect -> Instr<=RData, InstrPC<=FetchPC, InstrValid<=1, FetchPC<=FetchPC+PC_STEP (mod 2^32, wraps), go to HOLD.
  - RValid=1 with Redirect -> data discarded, FetchPC<=RedirectPC, go to REQ.
  - RValid=0 with Redirect -> FetchPC<=RedirectPC, go to DROP.
- DROP: IMemReq=0; wait for RValid, discard the data, then go to REQ. A further Redirect in DROP updates FetchPC and stays in DROP.
- HOLD: InstrValid=1; Instr and InstrPC are stable until the handshake.
  - DecodeReady=1, no Redirect -> InstrValid<=0, RetireCount+=1 (wraps), then go to IDLE if Halt=1, else REQ.
  - Redirect (with or without DecodeReady) -> instruction squashed, InstrValid<=0, RetireCount unchanged, FetchPC<=RedirectPC, go to REQ (IDLE if Halt=1).
- Redirect always takes priority over handshake and data events in the same cycle.
- Halt in IDLE holds IDLE even with Start=1.
- Steady-state throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with single-cycle memory and decode always ready.

Test Plan:
- Reset, Start=1, memory grants immediately and returns data 1 cycle later, DecodeReady=1 -> InstrPC sequence 0x0, 0x4, 0x8; RetireCount=3 after 3 handshakes; IMemReq low during WAIT/HOLD.
- Redirect=1, RedirectPC=0x0000_0103 asserted in WAIT before RValid -> DROP; the returning data is not presented; next IMemAddr=0x100; next InstrPC=0x100.
- Redirect in HOLD in the same cycle as DecodeReady=1 -> InstrValid falls; RetireCount unchanged; next request address = RedirectPC.
- DecodeReady held low 5 cycles in HOLD -> Instr, InstrPC and InstrValid stable; no new IMemReq; FetchPC already advanced by 4.
- RESET_PC=32'hFFFF_FFFC, fetch one instruction -> InstrPC=0xFFFF_FFFC, FetchPC wraps to 0x0000_0000.
- Reset asserted in WAIT, RValid arrives 2 cycles after reset release -> no InstrValid; FSM in IDLE; FetchPC=RESET_PC.
